// File: rtl/signed_div_pow2_pipe_if.sv
// Stream bundle for the signed divide-by-2^s pipe.
// Valid/ready rule: a beat moves on a rising edge where valid and ready are
// both 1; the producer holds its payload steady until that edge, and the
// consumer may raise or lower ready at any time.
interface signed_div_pow2_pipe_if #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
);
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic [SW-1:0] in_shift;
  logic          in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_quot;
  logic [N-1:0]  out_rem;

  modport master (
    output in_valid, in_data, in_shift, in_mode, out_ready,
    input  in_ready, out_valid, out_quot, out_rem
  );

  modport slave (
    input  in_valid, in_data, in_shift, in_mode, out_ready,
    output in_ready, out_valid, out_quot, out_rem
  );
endinterface

// File: rtl/signed_div_pow2_pipe.sv
// Two-stage signed divide by 2^s with floor or truncate rounding.
// Stage 1 adds the rounding bias, stage 2 shifts and forms the remainder.
module signed_div_pow2_pipe #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input logic                  clk,
  input logic                  rst,
  signed_div_pow2_pipe_if.slave bus
);
  logic          s1_valid;
  logic [N:0]    s1_sum;
  logic [SW-1:0] s1_shift;
  logic [N-1:0]  s1_a;
  logic          out_valid_r;
  logic [N-1:0]  quot_r;
  logic [N-1:0]  rem_r;

  logic          s2_free;
  logic          in_ready_w;
  logic [SW-1:0] shift_eff;
  logic [N:0]    bias;
  logic [N:0]    sum_next;
  logic [N-1:0]  q_next;
  logic [N-1:0]  r_next;

  assign s2_free    = !out_valid_r || bus.out_ready;
  assign in_ready_w = !s1_valid || s2_free;

  // Shift codes above N-1 only exist when N is not a power of two.
  generate
    if ((1 << SW) > N) begin : g_clamp
      assign shift_eff = (bus.in_shift > SW'(N - 1)) ? SW'(N - 1) : bus.in_shift;
    end else begin : g_no_clamp
      assign shift_eff = bus.in_shift;
    end
  endgenerate

  // Negative dividends in truncate mode get 2^s-1 added so the shift rounds toward zero.
  always_comb begin
    bias = '0;
    if (bus.in_mode && bus.in_data[N-1]) begin
      bias = ((N+1)'(1) << shift_eff) - (N+1)'(1);
    end
  end

  assign sum_next = {bus.in_data[N-1], bus.in_data} + bias;
  assign q_next   = N'($signed(s1_sum) >>> s1_shift);
  assign r_next   = s1_a - (q_next << s1_shift);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_sum      <= '0;
      s1_shift    <= '0;
      s1_a        <= '0;
      out_valid_r <= 1'b0;
      quot_r      <= '0;
      rem_r       <= '0;
    end else begin
      if (s2_free) begin
        out_valid_r <= s1_valid;
        if (s1_valid) begin
          quot_r <= q_next;
          rem_r  <= r_next;
        end
      end
      if (in_ready_w) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_sum   <= sum_next;
          s1_shift <= shift_eff;
          s1_a     <= bus.in_data;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_r;
  assign bus.out_quot  = quot_r;
  assign bus.out_rem   = rem_r;
endmodule
